tt_proj_port_driver: RTL and testbench
======================================

Name: tt_proj_port_driver

Overview:
- Controller-side counterpart of a per-project pin wrapper.
- Selects one of NUM_PROJ user projects and drives its 18-bit iw bundle: {uio_in[7:0], ui_in[7:0], rst_n, clk}.
- Generates a divided project clock and sequences project reset on every selection change.
- Captures the selected project's 24-bit ow bundle, {uio_oe, uio_out, uo_out}, into registered pad-side outputs.

Parameters:
- NUM_PROJ, 16, number of attached projects; ena is one-hot over this width.
- ADDR_W, 4, select address width; must satisfy 2**ADDR_W >= NUM_PROJ.
- RST_CYCLES, 8, number of project clock periods rst_n is held low after selection (minimum 1).
- DIV_W, 8, width of the clock divider register.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sel_valid  in  1  selection request valid.
- sel_addr  in  ADDR_W  requested project index.
- sel_ready  out  1  request accepted this cycle.
- clk_div  in  DIV_W  half-period of the project clock in clk cycles; 0 is treated as 1.
- ext_ui_in  in  8  pad inputs.
- ext_uio_in  in  8  bidir pad inputs.
- ena  out  NUM_PROJ  one-hot project enable.
- iw  out  18  {uio_in, ui_in, rst_n, clk} to the selected project.
- ow  in  24  muxed {uio_oe, uio_out, uo_out} from the selected project.
- uo_out_q  out  8  registered uo_out.
- uio_out_q  out  8  registered uio_out.
- uio_oe_q  out  8  registered uio_oe.
- running  out  1  selected project is out of reset.

Behaviour:
- Reset values: ena=0, iw=0 (project clock 0, rst_n 0), uo_out_q=0, uio_out_q=0, uio_oe_q=0, running=0, sel_ready=0. FSM resets to IDLE.
- FSM states: IDLE, DESEL, RESET, RUN.
  - IDLE: sel_ready=1. On sel_valid with sel_addr<NUM_PROJ, latch the address and go to DESEL. An out-of-range address is accepted (sel_ready=1) but ignored; the state stays put.
  - DESEL: one clk cycle; ena=0, project clock forced 0, rst_n=0. Next state is RESET.
  - RESET:
    - ena[latched]=1; the project clock toggles.
    - rst_n=0 until RST_CYCLES rising edges of the project clock have elapsed.
    - rst_n rises coincident with a project clock falling edge; the state then moves to RUN.
  - RUN: running=1; sel_ready=1. A new valid in-range request moves to DESEL, deasserting ena and running on the next cycle.
- Project clock:
  - Divider counter counts 0..max(clk_div,1)-1; iw[0] toggles at wrap.
  - iw[0] is a registered output; no glitches.
  - The counter is cleared in DESEL.
  - A change to clk_div takes effect at the next wrap.
- ui_in and uio_in: iw[9:2]=ext_ui_in and iw[17:10]=ext_uio_in, registered, 1 clk latency. Both are driven to 0 unless the state is RESET or RUN.
- Output capture:
  - ow is sampled on the clk cycle in which iw[0] transitions 1->0 (project falling edge), giving the project half a period to settle.
  - Captured bits: uo_out_q=ow[7:0], uio_out_q=ow[15:8], uio_oe_q=ow[23:16].
  - In IDLE and DESEL all three outputs are forced to 0 (bidir pads released).
- Simultaneous events: sel_valid in the same cycle as an internal RESET->RUN transition is not accepted; sel_ready=0 in RESET.
- rst asserted mid-operation returns everything to reset values on the next clk edge, regardless of state.

Optional Feature:
- Macro: TT_OW_SYNC_EN.
- Defined: ow passes through a 2-flop synchronizer on clk before capture; capture uses the synchronized value, so capture latency is +2 clk cycles. In this mode, captured outputs lag ow by 2 clk cycles.
- Undefined: ow is sampled directly at the capture cycle.

Test Plan:
- Reset: hold rst 3 cycles -> all outputs 0, sel_ready=0, then 1 in IDLE on the cycle after rst drops.
- Select: sel_addr=5, clk_div=2, RST_CYCLES=8 -> ena=16'h0020; iw[1]=0 for 8 project clock periods (32 clk cycles plus DESEL); then running=1.
- Capture: in RUN, ow=24'hA5_3C_F0 held -> after the next project falling edge, uo_out_q=F0, uio_out_q=3C, uio_oe_q=A5. With TT_OW_SYNC_EN, capture occurs 2 cycles later.
- Reselect in RUN: sel_addr=2 -> one DESEL cycle with ena=0 and uio_oe_q=0, then ena=16'h0004 and the reset sequence restarts.
- Out-of-range: NUM_PROJ=16, request sel_addr=... (ADDR_W=5 build) 20 -> sel_ready=1, state unchanged, ena unchanged.
- Mid-run rst pulse of 1 cycle -> ena=0, iw=0, running=0 next cycle; FSM in IDLE.

Source files
------------

// File: rtl/tt_proj_port_driver.sv
// Controller-side driver for a bank of tiny projects: selects one, sequences its reset,
// generates its divided clock and captures its outputs. Define TT_OW_SYNC_EN to synchronize ow.
module tt_proj_port_driver #(
  parameter int unsigned NUM_PROJ   = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned RST_CYCLES = 8,
  parameter int unsigned DIV_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_valid,
  input  logic [ADDR_W-1:0]   sel_addr,
  output logic                sel_ready,
  input  logic [DIV_W-1:0]    clk_div,
  input  logic [7:0]          ext_ui_in,
  input  logic [7:0]          ext_uio_in,
  output logic [NUM_PROJ-1:0] ena,
  output logic [17:0]         iw,
  input  logic [23:0]         ow,
  output logic [7:0]          uo_out_q,
  output logic [7:0]          uio_out_q,
  output logic [7:0]          uio_oe_q,
  output logic                running
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DESEL = 2'd1;
  localparam logic [1:0] ST_RESET = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]    div_max_q, div_max_d;
  logic [RC_W-1:0]     rise_cnt_q, rise_cnt_d;
  logic                pclk_q, pclk_d;
  logic                rst_n_q, rst_n_d;
  logic [7:0]          ui_q, ui_d;
  logic [7:0]          uio_q, uio_d;
  logic [NUM_PROJ-1:0] ena_q, ena_d;
  logic                running_q, running_d;
  logic                sel_ready_q, sel_ready_d;
  logic [7:0]          uo_out_d, uio_out_d, uio_oe_d;

  logic                sel_acc_c;
  logic                active_c;
  logic                active_next_c;
  logic                wrap_c;
  logic                fall_c;
  logic [DIV_W-1:0]    div_max_in_c;
  logic                cap_stb_c;
  logic [23:0]         cap_src_c;

`ifdef TT_OW_SYNC_EN
  logic [23:0] ow_s1_q, ow_s2_q;
  logic [1:0]  fall_dly_q;

  // Two-stage synchronizer; the capture strobe is delayed to stay aligned with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ow_s1_q    <= '0;
      ow_s2_q    <= '0;
      fall_dly_q <= '0;
    end else begin
      ow_s1_q    <= ow;
      ow_s2_q    <= ow_s1_q;
      fall_dly_q <= {fall_dly_q[0], fall_c};
    end
  end

  assign cap_stb_c = fall_dly_q[1];
  assign cap_src_c = ow_s2_q;
`else
  assign cap_stb_c = fall_c;
  assign cap_src_c = ow;
`endif

  // Next-state, project clock generation and output capture.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    div_cnt_d    = '0;
    div_max_d    = div_max_q;
    rise_cnt_d   = '0;
    pclk_d       = 1'b0;
    div_max_in_c = (clk_div == '0) ? '0 : clk_div - DIV_W'(1);
    wrap_c       = (div_cnt_q == div_max_q);
    sel_acc_c    = sel_valid && sel_ready_q && (32'(sel_addr) < NUM_PROJ);

    case (state_q)
      ST_IDLE: begin
        if (sel_acc_c) begin
          addr_d  = sel_addr;
          state_d = ST_DESEL;
        end
      end
      ST_DESEL: state_d = ST_RESET;
      ST_RESET: begin
        if (wrap_c && pclk_q && (rise_cnt_q >= RC_W'(RST_CYCLES))) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sel_acc_c) begin
          addr_d  = sel_addr;
          state_d = ST_DESEL;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The divider only runs while staying in RESET/RUN; everything else parks it at 0.
    active_c = ((state_q == ST_RESET) || (state_q == ST_RUN)) && !sel_acc_c;
    if (active_c) begin
      rise_cnt_d = rise_cnt_q;
      pclk_d     = pclk_q;
      if (wrap_c) begin
        pclk_d    = ~pclk_q;
        div_max_d = div_max_in_c;
        if (!pclk_q && (rise_cnt_q != RC_W'(RST_CYCLES))) begin
          rise_cnt_d = rise_cnt_q + RC_W'(1);
        end
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end else begin
      div_max_d = div_max_in_c;
    end
    fall_c = pclk_q && !pclk_d;

    active_next_c = (state_d == ST_RESET) || (state_d == ST_RUN);
    rst_n_d       = (state_d == ST_RUN);
    running_d     = (state_d == ST_RUN);
    sel_ready_d   = (state_d == ST_IDLE) || (state_d == ST_RUN);
    ena_d         = active_next_c ? (NUM_PROJ'(1) << addr_d) : '0;
    ui_d          = active_next_c ? ext_ui_in  : 8'h00;
    uio_d         = active_next_c ? ext_uio_in : 8'h00;

    uo_out_d  = uo_out_q;
    uio_out_d = uio_out_q;
    uio_oe_d  = uio_oe_q;
    if (!active_next_c) begin
      uo_out_d  = 8'h00;
      uio_out_d = 8'h00;
      uio_oe_d  = 8'h00;
    end else if (cap_stb_c) begin
      uo_out_d  = cap_src_c[7:0];
      uio_out_d = cap_src_c[15:8];
      uio_oe_d  = cap_src_c[23:16];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      div_cnt_q   <= '0;
      div_max_q   <= '0;
      rise_cnt_q  <= '0;
      pclk_q      <= 1'b0;
      rst_n_q     <= 1'b0;
      ui_q        <= 8'h00;
      uio_q       <= 8'h00;
      ena_q       <= '0;
      running_q   <= 1'b0;
      sel_ready_q <= 1'b0;
      uo_out_q    <= 8'h00;
      uio_out_q   <= 8'h00;
      uio_oe_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      div_cnt_q   <= div_cnt_d;
      div_max_q   <= div_max_d;
      rise_cnt_q  <= rise_cnt_d;
      pclk_q      <= pclk_d;
      rst_n_q     <= rst_n_d;
      ui_q        <= ui_d;
      uio_q       <= uio_d;
      ena_q       <= ena_d;
      running_q   <= running_d;
      sel_ready_q <= sel_ready_d;
      uo_out_q    <= uo_out_d;
      uio_out_q   <= uio_out_d;
      uio_oe_q    <= uio_oe_d;
    end
  end

  assign iw        = {uio_q, ui_q, rst_n_q, pclk_q};
  assign ena       = ena_q;
  assign running   = running_q;
  assign sel_ready = sel_ready_q;

endmodule

// File: tb/tb_tt_proj_port_driver.sv
// Directed bench for tt_proj_port_driver (ADDR_W=5 build so out-of-range addresses exist).
module tb_tt_proj_port_driver;

`ifdef TT_OW_SYNC_EN
  localparam int CAP_LAT = 2;
`else
  localparam int CAP_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_valid;
  logic [4:0]  sel_addr;
  logic        sel_ready;
  logic [7:0]  clk_div;
  logic [7:0]  ext_ui_in;
  logic [7:0]  ext_uio_in;
  logic [15:0] ena;
  logic [17:0] iw;
  logic [23:0] ow;
  logic [7:0]  uo_out_q;
  logic [7:0]  uio_out_q;
  logic [7:0]  uio_oe_q;
  logic        running;

  int n_assert = 0;
  int n_fail   = 0;

  tt_proj_port_driver #(
    .NUM_PROJ(16), .ADDR_W(5), .RST_CYCLES(8), .DIV_W(8)
  ) dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_addr(sel_addr),
    .sel_ready(sel_ready), .clk_div(clk_div), .ext_ui_in(ext_ui_in),
    .ext_uio_in(ext_uio_in), .ena(ena), .iw(iw), .ow(ow),
    .uo_out_q(uo_out_q), .uio_out_q(uio_out_q), .uio_oe_q(uio_oe_q),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then land on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int rises;
    int rstn_hi;
    int cycles;
    int toggles;
    logic prev;

    rst = 1'b1; sel_valid = 1'b0; sel_addr = '0; clk_div = 8'd2;
    ext_ui_in = 8'h00; ext_uio_in = 8'h00; ow = 24'h0;

    // Reset
    tick(3);
    chk("rst_ena",       32'(ena), 32'h0);
    chk("rst_iw",        32'(iw), 32'h0);
    chk("rst_uo",        32'(uo_out_q), 32'h0);
    chk("rst_uio_out",   32'(uio_out_q), 32'h0);
    chk("rst_uio_oe",    32'(uio_oe_q), 32'h0);
    chk("rst_running",   32'(running), 32'h0);
    chk("rst_sel_ready", 32'(sel_ready), 32'h0);
    rst = 1'b0;
    tick(1);
    chk("idle_sel_ready", 32'(sel_ready), 32'h1);

    // Select project 5
    sel_valid = 1'b1; sel_addr = 5'd5; ext_ui_in = 8'h5A; ext_uio_in = 8'hC3;
    tick(1);
    sel_valid = 1'b0;
    chk("desel_ena",       32'(ena), 32'h0);
    chk("desel_iw",        32'(iw), 32'h0);
    chk("desel_sel_ready", 32'(sel_ready), 32'h0);
    tick(1);
    chk("reset_ena",       32'(ena), 32'h0020);
    chk("reset_rst_n",     32'(iw[1]), 32'h0);
    chk("reset_pads",      32'(iw[17:2]), 32'hC35A);
    chk("reset_sel_ready", 32'(sel_ready), 32'h0);

    rises = 0; rstn_hi = 0; prev = iw[0];
    for (int c = 2; c <= 32; c++) begin
      tick(1);
      if (iw[0] && !prev) rises++;
      if (iw[1] !== 1'b0) rstn_hi++;
      prev = iw[0];
    end
    chk("reset_rises",   32'(rises), 32'd8);
    chk("reset_rstn_lo", 32'(rstn_hi), 32'd0);
    chk("reset_pclk_hi", 32'(iw[0]), 32'h1);
    chk("reset_not_run", 32'(running), 32'h0);
    tick(1);
    chk("run_running",   32'(running), 32'h1);
    chk("run_rst_n",     32'(iw[1]), 32'h1);
    chk("run_pclk_fall", 32'(iw[0]), 32'h0);
    chk("run_sel_ready", 32'(sel_ready), 32'h1);

    // Capture on the next project falling edge
    ow = 24'hA53CF0;
    tick(2);
    chk("cap_before", 32'(uo_out_q), 32'h0);
    tick(1 + CAP_LAT);
    chk("cap_early", 32'(uo_out_q), 32'h0);
    tick(1);
    chk("cap_uo",      32'(uo_out_q), 32'hF0);
    chk("cap_uio_out", 32'(uio_out_q), 32'h3C);
    chk("cap_uio_oe",  32'(uio_oe_q), 32'hA5);

    // Pad input registered with one cycle latency
    ext_ui_in = 8'h96;
    chk("ui_old", 32'(iw[9:2]), 32'h5A);
    tick(1);
    chk("ui_new", 32'(iw[9:2]), 32'h96);

    // Reselect project 2 from RUN; requests during RESET are ignored
    sel_valid = 1'b1; sel_addr = 5'd2;
    tick(1);
    chk("resel_ena",       32'(ena), 32'h0);
    chk("resel_uio_oe",    32'(uio_oe_q), 32'h0);
    chk("resel_uo",        32'(uo_out_q), 32'h0);
    chk("resel_running",   32'(running), 32'h0);
    chk("resel_iw",        32'(iw), 32'h0);
    sel_addr = 5'd7;
    tick(1);
    chk("resel_reset_ena", 32'(ena), 32'h0004);
    chk("resel_sel_ready", 32'(sel_ready), 32'h0);
    tick(1);
    chk("reset_req_ignored", 32'(ena), 32'h0004);
    sel_valid = 1'b0;
    cycles = 0;
    while (!running && cycles < 100) begin
      tick(1);
      cycles++;
    end
    chk("resel_reset_len", 32'(cycles), 32'd31);
    chk("resel_run_ena",   32'(ena), 32'h0004);

    // clk_div=0 behaves as a half-period of one clk
    clk_div = 8'd0;
    tick(4);
    toggles = 0;
    for (int k = 0; k < 4; k++) begin
      prev = iw[0];
      tick(1);
      if (iw[0] !== prev) toggles++;
    end
    chk("div0_toggles", 32'(toggles), 32'd4);

    // Out-of-range request in RUN is accepted and ignored
    sel_valid = 1'b1; sel_addr = 5'd20;
    chk("oor_run_ready", 32'(sel_ready), 32'h1);
    tick(1);
    sel_valid = 1'b0;
    chk("oor_run_running", 32'(running), 32'h1);
    chk("oor_run_ena",     32'(ena), 32'h0004);
    chk("oor_run_ready2",  32'(sel_ready), 32'h1);

    // Mid-run synchronous reset pulse
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_ena",       32'(ena), 32'h0);
    chk("midrst_iw",        32'(iw), 32'h0);
    chk("midrst_running",   32'(running), 32'h0);
    chk("midrst_sel_ready", 32'(sel_ready), 32'h0);
    chk("midrst_uio_oe",    32'(uio_oe_q), 32'h0);
    tick(1);
    chk("midrst_idle_ready", 32'(sel_ready), 32'h1);

    // Out-of-range in IDLE, then a valid request to project 0
    sel_valid = 1'b1; sel_addr = 5'd20;
    tick(1);
    chk("oor_idle_ready", 32'(sel_ready), 32'h1);
    chk("oor_idle_ena",   32'(ena), 32'h0);
    sel_addr = 5'd0;
    tick(1);
    sel_valid = 1'b0;
    chk("sel0_desel_ready", 32'(sel_ready), 32'h0);
    tick(1);
    chk("sel0_ena", 32'(ena), 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
